encoder_pulse_gen: RTL and testbench

Programmable encoder-signal generator: emits a burst of encoder pulses on A (and quadrature B when compiled in) at a commanded rate, direction and count. It is the transmit-side counterpart of the encoder counter and drives that block's A input in closed-loop benches and on-board self-test. It replaces free-running toggle stimulus with an exact, cycle-deterministic pulse train.

---
 rtl/encoder_pulse_gen.sv | 162 ++++++++++++++++
 tb/tb_encoder_pulse_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/encoder_pulse_gen.sv
// Programmable encoder pulse-train generator: emits Steps full A cycles of 4*Q clocks each.
// Optional macro QUAD_B_EN enables the quadrature B channel and Dir-selected lead/lag.
module encoder_pulse_gen (
  input  logic        CLK,
  input  logic        RST,
  input  logic        En,
  input  logic        Start,
  input  logic        Dir,
  input  logic [15:0] Period,
  input  logic [7:0]  Steps,
  output logic        A,
  output logic        B,
  output logic        Busy,
  output logic        Done,
  output logic [7:0]  Sent
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  phase_r, phase_s;
  logic [15:0] timer_r, timer_s;
  logic [15:0] q_r, q_s;
  logic [7:0]  steps_r, steps_s;
  logic        dir_r, dir_s;
  logic        a_s, b_s, busy_s, done_s;
  logic [7:0]  sent_s;

  // A level per phase; rev selects the channel that lags
  function automatic logic phase_a(input logic [1:0] ph, input logic rev);
    logic a;
    case (ph)
      2'd0:    a = 1'b0;
      2'd1:    a = ~rev;
      2'd2:    a = 1'b1;
      2'd3:    a = rev;
      default: a = 1'b0;
    endcase
    return a;
  endfunction

`ifdef QUAD_B_EN
  function automatic logic phase_b(input logic [1:0] ph, input logic rev);
    logic b;
    case (ph)
      2'd0:    b = 1'b0;
      2'd1:    b = rev;
      2'd2:    b = 1'b1;
      2'd3:    b = ~rev;
      default: b = 1'b0;
    endcase
    return b;
  endfunction
`else
  // Dir is still captured so the burst context is the same in both builds
  logic dir_unused_s;
  assign dir_unused_s = dir_r;
`endif

  // State and burst-context registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= ST_IDLE;
      phase_r <= 2'd0;
      timer_r <= 16'd0;
      q_r     <= 16'd0;
      steps_r <= 8'd0;
      dir_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      timer_r <= timer_s;
      q_r     <= q_s;
      steps_r <= steps_s;
      dir_r   <= dir_s;
    end
  end

  // Next-state and quarter-cycle timer logic
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    timer_s = timer_r;
    q_s     = q_r;
    steps_s = steps_r;
    dir_s   = dir_r;
    case (state_r)
      ST_IDLE: begin
        if (En && Start) begin
          q_s     = (Period == 16'd0) ? 16'd1 : Period;
          steps_s = Steps;
          dir_s   = Dir;
          phase_s = 2'd0;
          timer_s = q_s - 16'd1;
          state_s = (Steps == 8'd0) ? ST_DONE : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!En) begin
          state_s = ST_RUN;
        end else if (timer_r == 16'd0) begin
          phase_s = phase_r + 2'd1;
          timer_s = q_r - 16'd1;
          // Sent reaches Steps during the last cycle, so the wrap to phase 0 ends the burst
          if (phase_r == 2'd3 && Sent == steps_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          timer_s = timer_r - 16'd1;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output values derived from the next state so every output leaves a flop
  always_comb begin
`ifdef QUAD_B_EN
    a_s = phase_a(phase_s, dir_s);
    b_s = phase_b(phase_s, dir_s);
`else
    a_s = phase_a(phase_s, 1'b0);
    b_s = 1'b0;
`endif
    busy_s = (state_s == ST_RUN);
    done_s = (state_s == ST_DONE);
    if (state_r == ST_IDLE && state_s != ST_IDLE) begin
      sent_s = 8'd0;
    end else if (a_s && !A) begin
      sent_s = Sent + 8'd1;
    end else begin
      sent_s = Sent;
    end
  end

  // Output registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      A    <= 1'b0;
      B    <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
      Sent <= 8'd0;
    end else begin
      A    <= a_s;
      B    <= b_s;
      Busy <= busy_s;
      Done <= done_s;
      Sent <= sent_s;
    end
  end

endmodule

// File: tb/tb_encoder_pulse_gen.sv
// Self-checking bench for encoder_pulse_gen: directed and random bursts against an
// arithmetic model of the pulse timing (honours QUAD_B_EN).
module tb_encoder_pulse_gen;

  logic        CLK = 1'b0;
  logic        RST, En, Start, Dir;
  logic [15:0] Period;
  logic [7:0]  Steps;
  logic        A, B, Busy, Done;
  logic [7:0]  Sent;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  last_sent = 8'd0;

  always #5 CLK = ~CLK;

  encoder_pulse_gen dut (
    .CLK(CLK), .RST(RST), .En(En), .Start(Start), .Dir(Dir),
    .Period(Period), .Steps(Steps),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .Sent(Sent)
  );

  // Expected {A,B,Busy,Done,Sent} after eff enabled edges since the Start edge
  function automatic logic [11:0] model(input int eff, input int q, input int s, input bit d);
    int total, p, cyc, sent;
    bit rev, a, b;
    total = 4 * q * s;
    if (eff < total) begin
      p   = (eff / q) % 4;
      cyc = eff / (4 * q);
      rev = d;
`ifndef QUAD_B_EN
      rev = 1'b0;
`endif
      if (!rev) begin
        a = (p == 1 || p == 2);
        b = (p >= 2);
        sent = cyc + ((p >= 1) ? 1 : 0);
      end else begin
        a = (p >= 2);
        b = (p == 1 || p == 2);
        sent = cyc + ((p >= 2) ? 1 : 0);
      end
`ifndef QUAD_B_EN
      b = 1'b0;
`endif
      return {a, b, 1'b1, 1'b0, 8'(sent)};
    end else if (eff == total) begin
      return {4'b0001, 8'(s)};
    end else begin
      return {4'b0000, 8'(s)};
    end
  endfunction

  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {A, B, Busy, Done, Sent};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed A=%b B=%b Busy=%b Done=%b Sent=%0d, expected A=%b B=%b Busy=%b Done=%b Sent=%0d",
             tag, obs[11], obs[10], obs[9], obs[8], obs[7:0], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic burst(input string tag, input int per, input int s, input bit d,
                       input int gap_at, input int gap_len, input bit disturb);
    int q, total, eff, gap_rem;
    q = (per == 0) ? 1 : per;
    total = 4 * q * s;
    gap_rem = gap_len;
    Start = 1'b1; En = 1'b1; Period = 16'(per); Steps = 8'(s); Dir = d;
    @(posedge CLK); #1;
    Start = 1'b0;
    eff = 0;
    forever begin
      chk(tag, model(eff, q, s, d));
      if (eff == total + 1) break;
      En = 1'b1;
      if (gap_rem > 0 && eff == gap_at) begin
        En = 1'b0;
        gap_rem--;
      end
      Start = disturb && (eff == 3);
      if (disturb && eff == 3) begin
        Period = 16'($urandom);
        Steps  = 8'($urandom);
        Dir    = ~d;
      end
      @(posedge CLK); #1;
      if (En || eff >= total) eff++;
    end
    Start = 1'b0;
    En = 1'b1;
    last_sent = 8'(s);
  endtask

  initial begin
    int per, s, gat, glen;
    bit d;
    RST = 1'b0; En = 1'b0; Start = 1'b0; Dir = 1'b0; Period = 16'd0; Steps = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset", 12'h000);
    RST = 1'b1; En = 1'b1;
    @(posedge CLK); #1;
    chk("idle", {4'b0000, last_sent});

    // Start with En=0 must be ignored
    En = 1'b0; Start = 1'b1; Steps = 8'd2; Period = 16'd1;
    repeat (2) begin
      @(posedge CLK); #1;
      chk("start_en0", {4'b0000, last_sent});
    end
    Start = 1'b0; En = 1'b1;

    burst("fwd_q2_s3", 2, 3, 1'b0, -1, 0, 1'b0);
    burst("rev_q1_s2", 1, 2, 1'b1, -1, 0, 1'b0);
    burst("steps0",    3, 0, 1'b0, -1, 0, 1'b0);
    burst("period0",   0, 2, 1'b1, -1, 0, 1'b0);
    burst("period1",   1, 2, 1'b1, -1, 0, 1'b0);
    burst("en_gap",    4, 1, 1'b0, 5, 7, 1'b0);
    burst("disturb",   2, 3, 1'b0, -1, 0, 1'b1);

    // Long-period burst aborted by reset: no Done, everything cleared
    Start = 1'b1; Period = 16'hFFFF; Steps = 8'd5; Dir = 1'b0;
    @(posedge CLK); #1;
    Start = 1'b0;
    chk("long_run", model(0, 65535, 5, 1'b0));
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      chk("long_run", model(k, 65535, 5, 1'b0));
    end
    RST = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      chk("rst_mid", 12'h000);
    end
    RST = 1'b1;
    last_sent = 8'd0;
    repeat (5) begin
      @(posedge CLK); #1;
      chk("post_rst", 12'h000);
    end

    for (int i = 0; i < 12; i++) begin
      per  = int'($urandom_range(0, 3));
      s    = int'($urandom_range(0, 4));
      d    = 1'($urandom_range(0, 1));
      gat  = int'($urandom_range(0, 20));
      glen = int'($urandom_range(0, 3));
      burst("random", per, s, d, gat, glen, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
